// File: rtl/hsv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hsv_pkg
// Description : Shared constants and helpers for the HSV enhancement slice.
//               Pixel words are {H, S, V} with H in the most significant
//               field; channel indices give each field's position.
// Revision    : 1.0 - initial release
// ============================================================================
package hsv_pkg;

    localparam int CH_W_DEFAULT = 8;

    // Field position of each channel inside a pixel word (0 = LSB field)
    localparam int CH_H = 2;
    localparam int CH_S = 1;
    localparam int CH_V = 0;

    // LSB index of channel 'ch' in a pixel built from 'ch_w'-bit fields
    function automatic int ch_lsb(input int ch, input int ch_w);
        return ch * ch_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hsv_offset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hsv_offset_ctrl
// Description : One user-adjustable channel offset with hold-to-accelerate
//               stepping. The offset moves by STEP on each update while a
//               single direction is held; after REPEAT_FRAMES consecutive
//               updates in that direction the step becomes STEP*ACCEL.
//               WRAP=1 : offset is modulo MAXV+1 (range 0..MAXV)
//               WRAP=0 : offset saturates at +/-MAXV
// Ports       : clk, rst (async, active low)
//               update  - frame-boundary update strobe (already gated)
//               clear   - synchronous clear of offset and hold counter
//               inc/dec - button levels
//               offset  - current offset, two's complement, OW bits
//               accel   - channel is stepping at the accelerated rate
// Revision    : 1.0 - initial release
// ============================================================================
module hsv_offset_ctrl #(
    parameter int OW            = 9,
    parameter int STEP          = 1,
    parameter int REPEAT_FRAMES = 8,
    parameter int ACCEL         = 4,
    parameter int WRAP          = 0,
    parameter int MAXV          = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 update,
    input  logic                 clear,
    input  logic                 inc,
    input  logic                 dec,
    output logic signed [OW-1:0] offset,
    output logic                 accel
);

    localparam int                     c_SW        = OW + 1;
    localparam int                     c_CW        = $clog2(REPEAT_FRAMES + 1);
    localparam logic [c_CW-1:0]        c_CNT_MAX   = c_CW'(REPEAT_FRAMES);
    localparam logic signed [c_SW-1:0] c_STEP_BASE = c_SW'(STEP);
    localparam logic signed [c_SW-1:0] c_STEP_FAST = c_SW'(STEP * ACCEL);
    localparam logic signed [c_SW-1:0] c_LIM       = c_SW'(MAXV);
    localparam logic signed [c_SW-1:0] c_MOD       = c_SW'(MAXV + 1);

    logic signed [OW-1:0]   r_off;
    logic [c_CW-1:0]        r_cnt;
    logic                   r_dir;     // 1 = inc; only meaningful while r_cnt != 0

    logic                   w_single;
    logic                   w_change;
    logic                   w_fast;
    logic signed [c_SW-1:0] w_ext;
    logic signed [c_SW-1:0] w_step;
    logic signed [c_SW-1:0] w_sum;
    logic signed [c_SW-1:0] w_lim;
    logic signed [OW-1:0]   w_off_nxt;
    logic [c_CW-1:0]        w_cnt_nxt;
    logic                   w_dir_nxt;

    always_comb begin
        w_single  = inc ^ dec;
        // A running hold in the opposite direction restarts at base rate
        w_change  = (r_cnt != '0) && (r_dir != inc);
        w_fast    = (r_cnt >= c_CNT_MAX) && !w_change;
        w_step    = w_fast ? c_STEP_FAST : c_STEP_BASE;
        w_ext     = {r_off[OW-1], r_off};
        w_sum     = inc ? (w_ext + w_step) : (w_ext - w_step);

        w_lim = w_sum;
        if (WRAP != 0) begin
            // Steps never exceed one modulus, so one correction suffices
            if (w_sum < 0) begin
                w_lim = w_sum + c_MOD;
            end else if (w_sum > c_LIM) begin
                w_lim = w_sum - c_MOD;
            end
        end else begin
            if (w_sum > c_LIM) begin
                w_lim = c_LIM;
            end else if (w_sum < -c_LIM) begin
                w_lim = -c_LIM;
            end
        end

        w_off_nxt = r_off;
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (clear) begin
            w_off_nxt = '0;
            w_cnt_nxt = '0;
        end else if (update) begin
            if (inc && dec) begin
                w_off_nxt = '0;
                w_cnt_nxt = '0;
            end else if (w_single) begin
                w_off_nxt = OW'(w_lim);
                w_dir_nxt = inc;
                if (w_change) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt < c_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end else begin
                w_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_off <= '0;
            r_cnt <= '0;
            r_dir <= 1'b0;
        end else begin
            r_off <= w_off_nxt;
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
        end
    end

    assign offset = r_off;
    assign accel  = (r_cnt >= c_CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/hsv_adjust_pipe.sv
`default_nettype none
// ============================================================================
// Module      : hsv_adjust_pipe
// Description : HSV enhancement stage. Holds per-channel H/S/V offsets that
//               change only on the falling edge of vsync, and applies them
//               to a valid-qualified pixel stream with a fixed two-cycle
//               latency. Hue wraps modulo H_MAX+1; S and V saturate.
// Ports       : clk, rst (async, active low), vsync, enhance_en, user_in_en,
//               inc/dec_{hue,sat,val}, clr_offsets,
//               hsv_in/hsv_in_valid   - input pixel {H,S,V}
//               hsv_out/hsv_out_valid - adjusted pixel, 2 cycles later
//               h/s/v_offset          - current offsets
//               accel_active          - {h,s,v} accelerated-step flags
// Revision    : 1.0 - initial release
// ============================================================================
module hsv_adjust_pipe
    import hsv_pkg::*;
#(
    parameter int CH_W          = CH_W_DEFAULT,
    parameter int H_MAX         = 255,
    parameter int H_STEP        = 1,
    parameter int S_STEP        = 1,
    parameter int V_STEP        = 1,
    parameter int REPEAT_FRAMES = 8,
    parameter int ACCEL         = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vsync,
    input  logic                 enhance_en,
    input  logic                 user_in_en,
    input  logic                 inc_hue,
    input  logic                 dec_hue,
    input  logic                 inc_sat,
    input  logic                 dec_sat,
    input  logic                 inc_val,
    input  logic                 dec_val,
    input  logic                 clr_offsets,
    input  logic [3*CH_W-1:0]    hsv_in,
    input  logic                 hsv_in_valid,
    output logic [3*CH_W-1:0]    hsv_out,
    output logic                 hsv_out_valid,
    output logic [CH_W-1:0]      h_offset,
    output logic signed [CH_W:0] s_offset,
    output logic signed [CH_W:0] v_offset,
    output logic [2:0]           accel_active
);

    localparam int              c_XW        = CH_W + 2;
    localparam int              c_PW        = 3 * CH_W;
    localparam logic [CH_W-1:0] c_H_MAX_CH  = CH_W'(H_MAX);
    localparam logic [c_XW-1:0] c_H_MAX_X   = c_XW'(H_MAX);
    localparam logic [c_XW-1:0] c_H_MOD_X   = c_XW'(H_MAX + 1);
    localparam logic [c_XW-1:0] c_CH_MAX_X  = c_XW'((1 << CH_W) - 1);

    // ------------------------------------------------------------------
    // Frame-boundary detection and offset controllers
    // ------------------------------------------------------------------
    logic r_vsync;
    logic w_update;
    logic w_clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vsync <= 1'b0;
        end else begin
            r_vsync <= vsync;
        end
    end

    assign w_update = r_vsync & ~vsync & user_in_en;
    assign w_clear  = clr_offsets & user_in_en;

    logic signed [CH_W:0] w_h_off;
    logic signed [CH_W:0] w_s_off;
    logic signed [CH_W:0] w_v_off;
    logic                 w_acc_h;
    logic                 w_acc_s;
    logic                 w_acc_v;

    hsv_offset_ctrl #(
        .OW(CH_W + 1), .STEP(H_STEP), .REPEAT_FRAMES(REPEAT_FRAMES),
        .ACCEL(ACCEL), .WRAP(1), .MAXV(H_MAX)
    ) u_ctrl_h (
        .clk(clk), .rst(rst), .update(w_update), .clear(w_clear),
        .inc(inc_hue), .dec(dec_hue), .offset(w_h_off), .accel(w_acc_h)
    );

    hsv_offset_ctrl #(
        .OW(CH_W + 1), .STEP(S_STEP), .REPEAT_FRAMES(REPEAT_FRAMES),
        .ACCEL(ACCEL), .WRAP(0), .MAXV((1 << CH_W) - 1)
    ) u_ctrl_s (
        .clk(clk), .rst(rst), .update(w_update), .clear(w_clear),
        .inc(inc_sat), .dec(dec_sat), .offset(w_s_off), .accel(w_acc_s)
    );

    hsv_offset_ctrl #(
        .OW(CH_W + 1), .STEP(V_STEP), .REPEAT_FRAMES(REPEAT_FRAMES),
        .ACCEL(ACCEL), .WRAP(0), .MAXV((1 << CH_W) - 1)
    ) u_ctrl_v (
        .clk(clk), .rst(rst), .update(w_update), .clear(w_clear),
        .inc(inc_val), .dec(dec_val), .offset(w_v_off), .accel(w_acc_v)
    );

    // Hue offset is always within 0..H_MAX, so its low CH_W bits carry it
    assign h_offset     = w_h_off[CH_W-1:0];
    assign s_offset     = w_s_off;
    assign v_offset     = w_v_off;
    assign accel_active = {w_acc_h, w_acc_s, w_acc_v};

    // ------------------------------------------------------------------
    // Stage 1: widen and add offsets
    // ------------------------------------------------------------------
    logic [CH_W-1:0] w_h_in;
    logic [CH_W-1:0] w_s_in;
    logic [CH_W-1:0] w_v_in;
    logic [CH_W-1:0] w_h_clip;

    assign w_h_in   = hsv_in[ch_lsb(CH_H, CH_W) +: CH_W];
    assign w_s_in   = hsv_in[ch_lsb(CH_S, CH_W) +: CH_W];
    assign w_v_in   = hsv_in[ch_lsb(CH_V, CH_W) +: CH_W];
    // Out-of-range hue codes are treated as the largest legal hue
    assign w_h_clip = (w_h_in > c_H_MAX_CH) ? c_H_MAX_CH : w_h_in;

    logic [c_XW-1:0] r_hs;
    logic [c_XW-1:0] r_ss;
    logic [c_XW-1:0] r_vs;
    logic [c_PW-1:0] r_raw;
    logic            r_en;
    logic            r_valid1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hs     <= '0;
            r_ss     <= '0;
            r_vs     <= '0;
            r_raw    <= '0;
            r_en     <= 1'b0;
            r_valid1 <= 1'b0;
        end else begin
            r_hs     <= {2'b00, w_h_clip} + {w_h_off[CH_W], w_h_off};
            r_ss     <= {2'b00, w_s_in}   + {w_s_off[CH_W], w_s_off};
            r_vs     <= {2'b00, w_v_in}   + {w_v_off[CH_W], w_v_off};
            r_raw    <= hsv_in;
            r_en     <= enhance_en;
            r_valid1 <= hsv_in_valid;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: hue wrap, S/V clamp, bypass select
    // ------------------------------------------------------------------
    function automatic logic [CH_W-1:0] sat_u(input logic [c_XW-1:0] x);
        if (x[c_XW-1]) begin
            return '0;
        end else if (x > c_CH_MAX_X) begin
            return '1;
        end
        return CH_W'(x);
    endfunction

    function automatic logic [CH_W-1:0] hue_wrap(input logic [c_XW-1:0] x);
        return CH_W'((x > c_H_MAX_X) ? (x - c_H_MOD_X) : x);
    endfunction

    logic [c_PW-1:0] w_adj;

    always_comb begin
        w_adj = '0;
        w_adj[ch_lsb(CH_H, CH_W) +: CH_W] = hue_wrap(r_hs);
        w_adj[ch_lsb(CH_S, CH_W) +: CH_W] = sat_u(r_ss);
        w_adj[ch_lsb(CH_V, CH_W) +: CH_W] = sat_u(r_vs);
    end

    logic [c_PW-1:0] r_out;
    logic            r_valid2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out    <= '0;
            r_valid2 <= 1'b0;
        end else begin
            r_out    <= r_en ? w_adj : r_raw;
            r_valid2 <= r_valid1;
        end
    end

    assign hsv_out       = r_out;
    assign hsv_out_valid = r_valid2;

endmodule
`default_nettype wire
